// File: rtl/float_adder_seq.sv
// Multi-cycle floating-point adder with round-to-nearest-even and IEEE-style status flags.
// Alignment and normalisation step one bit per cycle; operands and results use valid/ready.
module float_adder_seq #(
    parameter int EXP_W = 8,
    parameter int FRAC_W = 23,
    localparam int W = 1 + EXP_W + FRAC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         overflow,
    output logic         underflow,
    output logic         inexact,
    output logic         invalid
);
    // Mantissa layout: {hidden, frac, G, R, S}; sum adds a carry bit on top.
    localparam int M = FRAC_W + 4;
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W:0]   E_ONE    = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0]   MAX_DIF  = (EXP_W+1)'(FRAC_W + 3);
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t          state_reg, state_next;
    logic [M-1:0]    big_reg, big_next, smal_reg, smal_next;
    logic [M:0]      sum_reg, sum_next;
    logic [EXP_W:0]  exp_reg, exp_next, dif_reg, dif_next;
    logic            sign_reg, sign_next, sub_reg, sub_next;
    logic [W-1:0]    out_reg, out_next;
    logic            ovf_reg, ovf_next, unf_reg, unf_next;
    logic            inx_reg, inx_next, inv_reg, inv_next;

    logic              x_sign, y_sign, b_sign, s_sign, x_big, x_nan, y_nan;
    logic [EXP_W-1:0]  x_exp, y_exp, b_exp, s_exp;
    logic [FRAC_W-1:0] x_frac, y_frac, b_frac, s_frac;
    logic [EXP_W:0]    dif_full, exp_fin;
    logic [M:0]        sum_v;
    logic [FRAC_W:0]   frac_rnd;
    logic              round_inc;

    assign {x_sign, x_exp, x_frac} = x;
    assign {y_sign, y_exp, y_frac} = y;
    assign x_nan = (x_exp == EXP_ONES) && (x_frac != '0);
    assign y_nan = (y_exp == EXP_ONES) && (y_frac != '0);
    // On a full tie x is treated as the larger operand.
    assign x_big = (x_exp > y_exp) || ((x_exp == y_exp) && (x_frac >= y_frac));
    assign {b_sign, b_exp, b_frac} = x_big ? x : y;
    assign {s_sign, s_exp, s_frac} = x_big ? y : x;
    assign dif_full = {1'b0, b_exp} - {1'b0, s_exp};

    assign sum_v     = sub_reg ? ({1'b0, big_reg} - {1'b0, smal_reg})
                               : ({1'b0, big_reg} + {1'b0, smal_reg});
    assign round_inc = sum_reg[2] & (sum_reg[1] | sum_reg[0] | sum_reg[3]);
    assign frac_rnd  = {1'b0, sum_reg[M-2:3]} + {{FRAC_W{1'b0}}, round_inc};
    assign exp_fin   = exp_reg + {{EXP_W{1'b0}}, frac_rnd[FRAC_W]};

    always_comb begin
        state_next = state_reg;
        big_next   = big_reg;
        smal_next  = smal_reg;
        sum_next   = sum_reg;
        exp_next   = exp_reg;
        dif_next   = dif_reg;
        sign_next  = sign_reg;
        sub_next   = sub_reg;
        out_next   = out_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        inx_next   = inx_reg;
        inv_next   = inv_reg;
        case (state_reg)
            IDLE: if (in_valid) begin
                ovf_next = 1'b0;
                unf_next = 1'b0;
                inx_next = 1'b0;
                inv_next = 1'b0;
                if (x_exp == EXP_ONES || y_exp == EXP_ONES) begin
                    state_next = DONE;
                    if (x_nan || y_nan || (x_exp == EXP_ONES && y_exp == EXP_ONES && x_sign != y_sign)) begin
                        out_next = QNAN;
                        inv_next = 1'b1;
                    end else if (x_exp == EXP_ONES) begin
                        out_next = {x_sign, EXP_ONES, {FRAC_W{1'b0}}};
                    end else begin
                        out_next = {y_sign, EXP_ONES, {FRAC_W{1'b0}}};
                    end
                end else if (s_exp == '0) begin
                    state_next = DONE;
                    if (b_exp == '0) out_next = {x_sign & y_sign, {(W-1){1'b0}}};
                    else             out_next = {b_sign, b_exp, b_frac};
                end else begin
                    state_next = ALIGN;
                    big_next   = {1'b1, b_frac, 3'b000};
                    sign_next  = b_sign;
                    sub_next   = b_sign ^ s_sign;
                    exp_next   = {1'b0, b_exp};
                    // Beyond the guard bits the smaller operand only contributes stickiness.
                    if (dif_full > MAX_DIF) begin
                        smal_next = {{(M-1){1'b0}}, 1'b1};
                        dif_next  = '0;
                    end else begin
                        smal_next = {1'b1, s_frac, 3'b000};
                        dif_next  = dif_full;
                    end
                end
            end
            ALIGN: begin
                if (dif_reg != '0) begin
                    smal_next = {1'b0, smal_reg[M-1:2], smal_reg[1] | smal_reg[0]};
                    dif_next  = dif_reg - E_ONE;
                end else begin
                    state_next = ADD;
                end
            end
            ADD: begin
                if (sum_v == '0) begin
                    out_next   = '0;
                    state_next = DONE;
                end else begin
                    sum_next   = sum_v;
                    state_next = NORM;
                end
            end
            NORM: begin
                // After a carry shift the hidden bit is always set, so go straight to rounding.
                if (sum_reg[M]) begin
                    sum_next   = {1'b0, sum_reg[M:2], sum_reg[1] | sum_reg[0]};
                    exp_next   = exp_reg + E_ONE;
                    state_next = ROUND;
                end else if (!sum_reg[M-1]) begin
                    if (exp_reg > E_ONE) begin
                        sum_next = sum_reg << 1;
                        exp_next = exp_reg - E_ONE;
                    end else begin
                        out_next   = {sign_reg, {(W-1){1'b0}}};
                        unf_next   = 1'b1;
                        inx_next   = 1'b1;
                        state_next = DONE;
                    end
                end else begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                state_next = DONE;
                inx_next   = sum_reg[2] | sum_reg[1] | sum_reg[0];
                if (exp_fin >= {1'b0, EXP_ONES}) begin
                    out_next = {sign_reg, EXP_ONES, {FRAC_W{1'b0}}};
                    ovf_next = 1'b1;
                    inx_next = 1'b1;
                end else begin
                    out_next = {sign_reg, exp_fin[EXP_W-1:0], frac_rnd[FRAC_W-1:0]};
                end
            end
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            big_reg   <= '0;
            smal_reg  <= '0;
            sum_reg   <= '0;
            exp_reg   <= '0;
            dif_reg   <= '0;
            sign_reg  <= 1'b0;
            sub_reg   <= 1'b0;
            out_reg   <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
            inx_reg   <= 1'b0;
            inv_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            big_reg   <= big_next;
            smal_reg  <= smal_next;
            sum_reg   <= sum_next;
            exp_reg   <= exp_next;
            dif_reg   <= dif_next;
            sign_reg  <= sign_next;
            sub_reg   <= sub_next;
            out_reg   <= out_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
            inx_reg   <= inx_next;
            inv_reg   <= inv_next;
        end
    end

    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = (state_reg == DONE);
    assign out       = out_reg;
    assign overflow  = ovf_reg;
    assign underflow = unf_reg;
    assign inexact   = inx_reg;
    assign invalid   = inv_reg;
endmodule

// File: tb/tb_float_adder_seq.sv
// Directed bench for float_adder_seq (single precision): hand-computed sums, flags,
// latencies, output stall, and reset during alignment.
module tb_float_adder_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic        overflow, underflow, inexact, invalid;

    int n_cmp = 0;
    int n_err = 0;

    float_adder_seq #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .overflow(overflow), .underflow(underflow), .inexact(inexact), .invalid(invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Flags packed as {overflow, underflow, inexact, invalid}.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_out, input logic [3:0] exp_flags,
                          input int exp_lat, input int hold);
        int lat;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        x = a;
        y = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("op %s: %h + %h -> %h flags=%b latency=%0d", tag, a, b, out,
                 {overflow, underflow, inexact, invalid}, lat);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_out"}, out, exp_out);
        check({tag, "_flags"}, {28'd0, overflow, underflow, inexact, invalid}, {28'd0, exp_flags});
        if (exp_lat > 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            x = 32'h4049_0FDB;
            y = 32'hC000_0000;
            in_valid = 1'b1;
            check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_hold_out"}, out, exp_out);
            check({tag, "_hold_flags"}, {28'd0, overflow, underflow, inexact, invalid}, {28'd0, exp_flags});
            check({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_post_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic seen;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", out, 32'd0);
        check("rst_flags", {28'd0, overflow, underflow, inexact, invalid}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", {31'd0, in_ready}, 32'd1);

        run_op("one_plus_one",  32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4'b0000, 5, 0);
        run_op("one_minus_one", 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 4'b0000, 3, 0);
        run_op("tie_even",      32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 4'b0010, 0, 0);
        run_op("tie_odd",       32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, 4'b0010, 0, 0);
        run_op("collapse",      32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000, 4'b0010, 5, 0);
        run_op("overflow",      32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 4'b1010, 0, 0);
        run_op("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b0001, 1, 0);
        run_op("nan_in",        32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b0001, 1, 0);
        run_op("inf_plus_one",  32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 4'b0000, 1, 0);
        run_op("align2",        32'h3FC0_0000, 32'h3E80_0000, 32'h3FE0_0000, 4'b0000, 0, 0);
        run_op("align2_swap",   32'h3E80_0000, 32'h3FC0_0000, 32'h3FE0_0000, 4'b0000, 0, 0);
        run_op("cancel",        32'h3F80_0000, 32'hBF40_0000, 32'h3E80_0000, 4'b0000, 0, 0);
        run_op("neg_zeros",     32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 4'b0000, 1, 0);
        run_op("mixed_zeros",   32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0000, 1, 0);
        run_op("zero_plus_pi",  32'h0000_0000, 32'h4049_0FDB, 32'h4049_0FDB, 4'b0000, 1, 0);
        run_op("underflow",     32'h0080_0001, 32'h8080_0000, 32'h0000_0000, 4'b0110, 0, 0);
        run_op("stall",         32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4'b0000, 5, 4);

        // Reset while the smaller operand is still being shifted.
        @(negedge clk);
        x = 32'h3F80_0000;
        y = 32'h3380_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        $display("op reset_mid_align: out=%h out_valid=%b in_ready=%b", out, out_valid, in_ready);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out", out, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check("midrst_no_result", {31'd0, seen}, 32'd0);
        check("midrst_ready_after", {31'd0, in_ready}, 32'd1);
        run_op("after_reset",   32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4'b0000, 5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
